// File: rtl/data_fifo_arb_pkg.sv
// Shared types and constants for the data FIFO write-side arbiter.
package data_fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 64;
  localparam int LEN_W_DEF  = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/data_fifo_wr_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester favoured on a tie
// and moves to the opposite of the requester whose burst just ended.
module rr_arb2
  import data_fifo_arb_pkg::*;
(
  input  logic       wclk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic       winner,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    winner = REQ0;
    if (req[0] && req[1]) begin
      winner = ptr;
    end else if (req[1]) begin
      winner = REQ1;
    end
  end

  assign grant = (|req) ? ((winner == REQ1) ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      ptr <= REQ0;
    end else if (done) begin
      ptr <= ~done_id;
    end
  end

endmodule

// File: rtl/data_fifo_wr_arbiter.sv
// Write-side arbiter sharing the async data FIFO write port between two burst requesters.
// Optional DATA_FIFO_ARB_LEN_CHECK_EN: also end bursts on counter==0 and flag len/last mismatches.
module data_fifo_wr_arbiter
  import data_fifo_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              wclk,
  input  logic              resetn,
  input  logic              req0_valid,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  input  logic              w0_valid,
  input  logic [DATA_W-1:0] w0_data,
  input  logic              w0_last,
  output logic              w0_ready,
  input  logic              req1_valid,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  input  logic              w1_valid,
  input  logic [DATA_W-1:0] w1_data,
  input  logic              w1_last,
  output logic              w1_ready,
  input  logic              fifo_full,
  output logic              fifo_write_en,
  output logic [DATA_W-1:0] fifo_data_in,
  output logic              grant_id,
  output logic              busy,
  output logic              burst_done,
  output logic              burst_err
);

  state_t            state, state_next;
  logic              grant_q;
  logic [LEN_W-1:0]  count;
  logic              winner;
  logic [1:0]        grant_oh;
  logic              sel_valid, sel_last, beat, burst_end, len_err, take;
  logic [DATA_W-1:0] sel_data;

  rr_arb2 u_rr_arb2 (
    .wclk    (wclk),
    .resetn  (resetn),
    .req     ({req1_valid, req0_valid}),
    .done    (burst_end),
    .done_id (grant_q),
    .winner  (winner),
    .grant   (grant_oh)
  );

  assign sel_valid = (grant_q == REQ1) ? w1_valid : w0_valid;
  assign sel_last  = (grant_q == REQ1) ? w1_last  : w0_last;
  assign sel_data  = (grant_q == REQ1) ? w1_data  : w0_data;

  assign beat = (state == XFER) && sel_valid && !fifo_full;
  // Grants are gated by resetn so no ready escapes while reset is held.
  assign take = (state == IDLE) && resetn && (|grant_oh);

`ifdef DATA_FIFO_ARB_LEN_CHECK_EN
  logic count_zero;
  assign count_zero = (count == '0);
  assign burst_end  = beat && (sel_last || count_zero);
  assign len_err    = beat && (sel_last != count_zero);
`else
  assign burst_end  = beat && sel_last;
  assign len_err    = 1'b0;
`endif

  assign fifo_write_en = beat;
  assign fifo_data_in  = beat ? sel_data : '0;
  assign grant_id      = grant_q;
  assign busy          = (state == XFER);

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    w0_ready   = 1'b0;
    w1_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          req0_ready = grant_oh[0];
          req1_ready = grant_oh[1];
          state_next = XFER;
        end
      end
      XFER: begin
        w0_ready = (grant_q == REQ0) && !fifo_full;
        w1_ready = (grant_q == REQ1) && !fifo_full;
        if (burst_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant_q    <= REQ0;
      count      <= '0;
      burst_done <= 1'b0;
      burst_err  <= 1'b0;
    end else begin
      state      <= state_next;
      burst_done <= burst_end;
      burst_err  <= len_err;
      if (take) begin
        grant_q <= winner;
        count   <= (winner == REQ1) ? req1_len : req0_len;
      end else if (beat && (count != '0)) begin
        count <= count - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_fifo_wr_arbiter.sv
// Randomized bench for data_fifo_wr_arbiter against a burst-level reference model.
module tb_data_fifo_wr_arbiter;

  localparam int DW = 64;
  localparam int LW = 8;

  logic          wclk = 1'b0;
  logic          resetn = 1'b0;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [LW-1:0] req0_len, req1_len;
  logic          w0_valid, w0_last, w0_ready, w1_valid, w1_last, w1_ready;
  logic [DW-1:0] w0_data, w1_data, fifo_data_in;
  logic          fifo_full, fifo_write_en, grant_id, busy, burst_done, burst_err;

  int checks = 0;
  int errors = 0;

  int owner = -1;
  int favour = 0;
  int grant_reg = 0;
  int sent = 0;
  int cur_len = 0;
  int cur_last_at = 0;
  int full_hold = 0;
  bit done_pend = 0;
  bit err_pend = 0;
  bit full = 0;
  bit pending [2];
  int p_len [2];
  int p_last_at [2];
  bit rvalid [2];
  bit wvalid [2];
  bit wlast [2];
  logic [DW-1:0] wdata [2];

  data_fifo_wr_arbiter #(.DATA_W(DW), .LEN_W(LW)) dut (
    .wclk(wclk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_len(req0_len), .req0_ready(req0_ready),
    .w0_valid(w0_valid), .w0_data(w0_data), .w0_last(w0_last), .w0_ready(w0_ready),
    .req1_valid(req1_valid), .req1_len(req1_len), .req1_ready(req1_ready),
    .w1_valid(w1_valid), .w1_data(w1_data), .w1_last(w1_last), .w1_ready(w1_ready),
    .fifo_full(fifo_full), .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in),
    .grant_id(grant_id), .busy(busy), .burst_done(burst_done), .burst_err(burst_err)
  );

  always #5 wclk = ~wclk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Last normally lands on beat len; sometimes one early or one late to exercise termination rules.
  task automatic newBurst(input int i);
    int r;
    pending[i] = 1'b1;
    p_len[i] = int'($urandom % 4);
    p_last_at[i] = p_len[i];
    r = int'($urandom % 8);
    if (r == 0) p_last_at[i] = p_len[i] + 1;
    else if (r == 1 && p_len[i] > 0) p_last_at[i] = p_len[i] - 1;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 2; i++) begin
      rvalid[i] = pending[i];
      if (owner == i) begin
        wvalid[i] = ($urandom % 4) != 0;
        wlast[i]  = (sent == cur_last_at);
      end else begin
        wvalid[i] = 1'($urandom);
        wlast[i]  = 1'($urandom);
      end
      wdata[i] = {$urandom, $urandom};
    end
    if (full_hold > 0) begin
      full = 1'b1;
      full_hold--;
    end else if ($urandom % 40 == 0) begin
      full = 1'b1;
      full_hold = 4;
    end else begin
      full = ($urandom % 5) == 0;
    end
    req0_valid = rvalid[0]; req0_len = LW'(p_len[0]);
    req1_valid = rvalid[1]; req1_len = LW'(p_len[1]);
    w0_valid = wvalid[0]; w0_last = wlast[0]; w0_data = wdata[0];
    w1_valid = wvalid[1]; w1_last = wlast[1]; w1_data = wdata[1];
    fifo_full = full;
  endtask

  task automatic runCycle();
    int win;
    bit beat, ends, err;
    logic [DW-1:0] exp_data;
    applyStimulus();
    #1;
    win = -1;
    if (owner < 0) begin
      if (rvalid[0] && rvalid[1]) win = favour;
      else if (rvalid[0]) win = 0;
      else if (rvalid[1]) win = 1;
    end
    beat = 1'b0;
    exp_data = '0;
    if (owner >= 0 && wvalid[owner] && !full) begin
      beat = 1'b1;
      exp_data = wdata[owner];
    end
    checkOutput("req0_ready", 64'(req0_ready), 64'(win == 0));
    checkOutput("req1_ready", 64'(req1_ready), 64'(win == 1));
    checkOutput("w0_ready", 64'(w0_ready), 64'(owner == 0 && !full));
    checkOutput("w1_ready", 64'(w1_ready), 64'(owner == 1 && !full));
    checkOutput("fifo_write_en", 64'(fifo_write_en), 64'(beat));
    checkOutput("fifo_data_in", fifo_data_in, exp_data);
    checkOutput("grant_id", 64'(grant_id), 64'(grant_reg));
    checkOutput("busy", 64'(busy), 64'(owner >= 0));
    checkOutput("burst_done", 64'(burst_done), 64'(done_pend));
    checkOutput("burst_err", 64'(burst_err), 64'(err_pend));

    done_pend = 1'b0;
    err_pend = 1'b0;
    if (win >= 0) begin
      owner = win;
      grant_reg = win;
      sent = 0;
      cur_len = p_len[win];
      cur_last_at = p_last_at[win];
      pending[win] = 1'b0;
    end else if (beat) begin
`ifdef DATA_FIFO_ARB_LEN_CHECK_EN
      ends = wlast[owner] || (sent == cur_len);
      err  = wlast[owner] != (sent == cur_len);
`else
      ends = wlast[owner];
      err  = 1'b0;
`endif
      sent++;
      if (ends) begin
        done_pend = 1'b1;
        err_pend = err;
        favour = 1 - owner;
        owner = -1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (!pending[i] && ($urandom % 3) == 0) newBurst(i);
    end
  endtask

  task automatic checkAllZero(input string phase);
    checkOutput({phase, "_req0_ready"}, 64'(req0_ready), 64'(0));
    checkOutput({phase, "_req1_ready"}, 64'(req1_ready), 64'(0));
    checkOutput({phase, "_w0_ready"}, 64'(w0_ready), 64'(0));
    checkOutput({phase, "_w1_ready"}, 64'(w1_ready), 64'(0));
    checkOutput({phase, "_fifo_write_en"}, 64'(fifo_write_en), 64'(0));
    checkOutput({phase, "_fifo_data_in"}, fifo_data_in, 64'(0));
    checkOutput({phase, "_grant_id"}, 64'(grant_id), 64'(0));
    checkOutput({phase, "_busy"}, 64'(busy), 64'(0));
    checkOutput({phase, "_burst_done"}, 64'(burst_done), 64'(0));
    checkOutput({phase, "_burst_err"}, 64'(burst_err), 64'(0));
  endtask

  // Reset lands between clock edges; both requesters stay pending so the favour reset is visible.
  task automatic resetMidBurst();
    @(negedge wclk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    w0_valid = 1'b1;
    w1_valid = 1'b1;
    fifo_full = 1'b0;
    #2 resetn = 1'b0;
    #1 checkAllZero("rst_mid");
    owner = -1; favour = 0; grant_reg = 0; sent = 0;
    done_pend = 1'b0; err_pend = 1'b0; full_hold = 0;
    newBurst(0);
    newBurst(1);
    @(negedge wclk);
    resetn = 1'b1;
  endtask

  initial begin
    int rst_at;
    int resets;
    pending[0] = 1'b1; p_len[0] = 1; p_last_at[0] = 1;
    pending[1] = 1'b1; p_len[1] = 1; p_last_at[1] = 1;
    applyStimulus();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    fifo_full = 1'b0;
    full = 1'b0;
    #3 checkAllZero("rst_init");
    @(negedge wclk);
    resetn = 1'b1;
    runCycle();
    rst_at = 600;
    resets = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > rst_at && owner >= 0 && sent >= 1) begin
        resetMidBurst();
        resets++;
        rst_at = cyc + 800;
      end else begin
        @(negedge wclk);
      end
      runCycle();
    end
    $display("[TB] mid-burst resets applied: %0d", resets);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_fifo_wr_arbiter.md
# data_fifo_wr_arbiter

Write-side arbiter for the bridge's 64-bit asynchronous data FIFO, in the `wclk` domain. It shares the FIFO write port between two burst requesters and grants whole bursts round-robin. It forwards each granted beat into the FIFO only when the FIFO is not full, and it reports completion of every burst.

## Interface
- `DATA_W`, 64, data beat width; must match the FIFO data width.
- `LEN_W`, 8, burst length field width; a burst carries `len+1` beats.
- `wclk`  in  1  write-domain clock; all logic is rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a burst pending.
- `req0_len`  in  LEN_W  requester 0 beat count minus one.
- `req0_ready`  out  1  requester 0 burst accepted this cycle.
- `w0_valid`  in  1  requester 0 beat valid.
- `w0_data`  in  DATA_W  requester 0 beat data.
- `w0_last`  in  1  requester 0 final beat of its burst.
- `w0_ready`  out  1  requester 0 beat accepted when high together with `w0_valid`.
- `req1_valid`, `req1_len`, `req1_ready`, `w1_valid`, `w1_data`, `w1_last`, `w1_ready`: same as requester 0, for requester 1.
- `fifo_full`  in  1  FIFO full flag, write domain.
- `fifo_write_en`  out  1  FIFO write strobe.
- `fifo_data_in`  out  DATA_W  FIFO write data.
- `grant_id`  out  1  requester that owns the current burst.
- `busy`  out  1  a burst is in progress.
- `burst_done`  out  1  one-cycle pulse after a burst's final beat.
- `burst_err`  out  1  one-cycle pulse with `burst_done` on a length/last mismatch; present only with the macro (see Configuration), otherwise tied 0.

## Operation
- FSM has two states.
  - IDLE: arbitrate among `reqX_valid`.
  - XFER: move beats for `grant_id`.
- Arbitration in IDLE uses a one-bit priority pointer.
  - The requester not granted last time wins ties.
  - A lone requester always wins.
  - The pointer resets to favour requester 0.
- In IDLE, `reqX_ready` is driven combinationally high for the winner only. On that cycle:
  - `grant_id` latches the winner;
  - the beat counter loads `reqX_len`;
  - the state moves to XFER.
- In XFER:
  - `wX_ready` = (X == `grant_id`) && !`fifo_full`.
  - The other requester's `wX_ready` is 0.
  - A beat transfers when `wX_valid` && `wX_ready`.
  - On a beat transfer, `fifo_write_en` = 1 and `fifo_data_in` = `wX_data` in the same cycle.
- `fifo_write_en` is never high while `fifo_full` = 1. When no beat transfers, `fifo_data_in` = 0.
- The counter decrements by 1 per transferred beat. It saturates at 0 and never wraps.
- Burst end (without the macro): the beat that carries `wX_last` ends the burst. The counter value is ignored for termination.
- Burst end leads to:
  - state IDLE;
  - a registered `burst_done` pulse on the next cycle;
  - the pointer toggled to favour the other requester.
- `busy` = (state == XFER).
- Reset (asynchronous, any time, including mid-burst) immediately forces:
  - state IDLE;
  - counter 0, `grant_id` 0, pointer to requester 0;
  - every output 0.
  - Partially written burst data already in the FIFO is not retracted.

## Timing
- Grant latency: 0 cycles. `reqX_ready` is high in the same cycle `reqX_valid` is seen in IDLE.
- The first beat can transfer on the cycle after grant.
- Beat throughput: 1 beat per cycle while the FIFO is not full.
- A full FIFO stalls the burst indefinitely. `wX_ready` returns the cycle `fifo_full` falls.
- After the final beat there is exactly 1 IDLE cycle before the next grant. Back-to-back bursts cost one bubble.
- `burst_done` and `burst_err` pulse 1 cycle after the final-beat transfer, for 1 cycle.
- `reqX_valid` seen during XFER is held off (`reqX_ready` = 0) until IDLE.

## Configuration
- `DATA_FIFO_ARB_LEN_CHECK_EN` defined:
  - the burst ends on the first beat with `wX_last` = 1 or with counter == 0;
  - `burst_err` pulses with `burst_done` when these two disagree, i.e. an early last or a missing last.
- `DATA_FIFO_ARB_LEN_CHECK_EN` undefined:
  - termination is on `wX_last` only;
  - `burst_err` is constant 0 and the counter comparison logic is omitted.

## Structure
- Shared package `data_fifo_arb_pkg` holds:
  - the FSM state enum (IDLE, XFER);
  - defaults for `DATA_W` and `LEN_W`;
  - requester-index constants.
- One sub-module, `rr_arb2`: the two-input round-robin arbiter with the priority pointer. It outputs a winner index and a one-hot grant, and the pointer updates on a burst-end strobe.

## Test plan
- Single burst: req0 `len`=3, 4 beats `0x11..0x44` with last on the 4th, FIFO never full.
  - Required: 4 consecutive `fifo_write_en` cycles with matching data, then `burst_done` 1 cycle later; `busy` falls.
- Contention: `req0_valid` and `req1_valid` both high from reset, each with `len`=1.
  - Required: req0 granted first, then req1 after a 1-cycle bubble; order continues to alternate over 4 bursts.
- Backpressure: `fifo_full`=1 for 5 cycles mid-burst.
  - Required: `w0_ready`=0 and `fifo_write_en`=0 throughout; transfer resumes the cycle `full` falls; no beat lost or duplicated.
- Reset mid-burst: assert `resetn`=0 after 2 of 8 beats.
  - Required: all outputs 0 immediately; after release, req1 is not favoured and the next req0 is granted fresh.
- With `DATA_FIFO_ARB_LEN_CHECK_EN`: `len`=3 but `w0_last` on beat 2.
  - Required: burst ends after 2 writes; `burst_done` and `burst_err` both pulse.
- Same macro: `len`=1 with no last.
  - Required: ends after 2 beats with `burst_err`.
- Without the macro: ends only on last, `burst_err`=0.
